// File: rtl/lotr_img_loader_if.sv
// Byte-stream ingress, word-write egress and load status of the image loader.
// The loader side uses the slave modport; the feeding environment uses master.
interface lotr_img_loader_if #(
    parameter int ADDR_W = 32
);
    logic              ByteValidQnnnH;
    logic [7:0]        ByteDataQnnnH;
    logic              ByteReadyQnnnH;
    logic              MemWrEnQnnnH;
    logic [ADDR_W-1:0] MemWrAddrQnnnH;
    logic [31:0]       MemWrDataQnnnH;
    logic              MemWrReadyQnnnH;
    logic              CoreRstQnnnH;
    logic              LoadDoneQnnnH;
    logic              LoadErrQnnnH;

    modport master (
        output ByteValidQnnnH, ByteDataQnnnH, MemWrReadyQnnnH,
        input  ByteReadyQnnnH, MemWrEnQnnnH, MemWrAddrQnnnH,
        input  MemWrDataQnnnH, CoreRstQnnnH, LoadDoneQnnnH, LoadErrQnnnH
    );

    modport slave (
        input  ByteValidQnnnH, ByteDataQnnnH, MemWrReadyQnnnH,
        output ByteReadyQnnnH, MemWrEnQnnnH, MemWrAddrQnnnH,
        output MemWrDataQnnnH, CoreRstQnnnH, LoadDoneQnnnH, LoadErrQnnnH
    );
endinterface

// File: rtl/lotr_img_loader.sv
// Streams a record-based boot image into tile memory, holding the cores in reset.
// Optional per-record checksum byte: define LOTR_LOADER_CHKSUM_EN.
module lotr_img_loader #(
    parameter int ADDR_W = 32
) (
    input logic              QClk,
    input logic              RstQnnnH,
    lotr_img_loader_if.slave bus
);

    typedef enum logic [2:0] {
        HDR_ADDR,
        HDR_CNT,
        DATA,
        WRITE,
        DONE,
        ERR
`ifdef LOTR_LOADER_CHKSUM_EN
        , CHK
`endif
    } state_t;

    state_t            state;
    logic [1:0]        idx;
    logic [23:0]       shReg;
    logic [15:0]       wordCnt;
    logic              byteReady;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [31:0]       wrData;
    logic              coreRst;
    logic              loadDone;
    logic              loadErr;
    logic              take;
    logic [7:0]        byteIn;
`ifdef LOTR_LOADER_CHKSUM_EN
    logic [7:0]        sum;
    logic              isEnd;
`endif

    assign take   = byteReady & bus.ByteValidQnnnH;
    assign byteIn = bus.ByteDataQnnnH;

    assign bus.ByteReadyQnnnH = byteReady;
    assign bus.MemWrEnQnnnH   = wrEn;
    assign bus.MemWrAddrQnnnH = wrAddr;
    assign bus.MemWrDataQnnnH = wrData;
    assign bus.CoreRstQnnnH   = coreRst;
    assign bus.LoadDoneQnnnH  = loadDone;
    assign bus.LoadErrQnnnH   = loadErr;

    // Bytes shift in from the top so shReg holds {b2,b1,b0} after three bytes.
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            state     <= HDR_ADDR;
            idx       <= '0;
            shReg     <= '0;
            wordCnt   <= '0;
            byteReady <= 1'b0;
            wrEn      <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            coreRst   <= 1'b1;
            loadDone  <= 1'b0;
            loadErr   <= 1'b0;
`ifdef LOTR_LOADER_CHKSUM_EN
            sum       <= '0;
            isEnd     <= 1'b0;
`endif
        end else begin
`ifdef LOTR_LOADER_CHKSUM_EN
            if (take) sum <= 8'(sum + byteIn);
`endif
            unique case (state)
                HDR_ADDR: begin
                    byteReady <= 1'b1;
                    if (take) begin
                        shReg <= {byteIn, shReg[23:8]};
                        idx   <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            if (shReg[1:0] != 2'b00) begin
                                state     <= ERR;
                                byteReady <= 1'b0;
                                loadErr   <= 1'b1;
                            end else begin
                                wrAddr <= ADDR_W'({byteIn, shReg});
                                state  <= HDR_CNT;
                            end
                        end
                    end
                end
                HDR_CNT: begin
                    byteReady <= 1'b1;
                    if (take) begin
                        shReg <= {byteIn, shReg[23:8]};
                        idx   <= (idx == 2'd1) ? 2'd0 : 2'd1;
                        if (idx == 2'd1) begin
                            wordCnt <= {byteIn, shReg[23:16]};
                            if ({byteIn, shReg[23:16]} == 16'd0) begin
`ifdef LOTR_LOADER_CHKSUM_EN
                                state <= CHK;
                                isEnd <= 1'b1;
`else
                                state     <= DONE;
                                byteReady <= 1'b0;
                                loadDone  <= 1'b1;
                                coreRst   <= 1'b0;
`endif
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    byteReady <= 1'b1;
                    if (take) begin
                        shReg <= {byteIn, shReg[23:8]};
                        idx   <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            wrData    <= {byteIn, shReg};
                            wrEn      <= 1'b1;
                            byteReady <= 1'b0;
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.MemWrReadyQnnnH) begin
                        wrEn      <= 1'b0;
                        wrAddr    <= wrAddr + ADDR_W'(4);
                        wordCnt   <= wordCnt - 16'd1;
                        byteReady <= 1'b1;
                        if (wordCnt == 16'd1) begin
`ifdef LOTR_LOADER_CHKSUM_EN
                            state <= CHK;
                            isEnd <= 1'b0;
`else
                            state <= HDR_ADDR;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
`ifdef LOTR_LOADER_CHKSUM_EN
                CHK: begin
                    byteReady <= 1'b1;
                    if (take) begin
                        sum <= '0;
                        if (8'(sum + byteIn) != 8'd0) begin
                            state     <= ERR;
                            byteReady <= 1'b0;
                            loadErr   <= 1'b1;
                        end else if (isEnd) begin
                            state     <= DONE;
                            byteReady <= 1'b0;
                            loadDone  <= 1'b1;
                            coreRst   <= 1'b0;
                        end else begin
                            state <= HDR_ADDR;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lotr_img_loader.md
LOTR_IMG_LOADER -- requirements
Module: lotr_img_loader

Interface
REQ-001 Parameter ADDR_W, default 32: width of the memory write address and header address field.
REQ-002 QClk  input  1  clock; all state updates on the rising edge.
REQ-003 RstQnnnH  input  1  asynchronous, active-high reset.
REQ-004 ByteValidQnnnH  input  1  image byte valid.
REQ-005 ByteDataQnnnH  input  8  image byte.
REQ-006 ByteReadyQnnnH  output  1  loader accepts byte; transfer when valid and ready are both high.
REQ-007 MemWrEnQnnnH  output  1  word write request to tile I_MEM/D_MEM write port.
REQ-008 MemWrAddrQnnnH  output  ADDR_W  byte address of the word, always 4-aligned.
REQ-009 MemWrDataQnnnH  output  32  write data, little-endian assembled.
REQ-010 MemWrReadyQnnnH  input  1  memory accepts write; completes when enable and ready are both high.
REQ-011 CoreRstQnnnH  output  1  reset to the gpc_4t tiles, held high until the load completes.
REQ-012 LoadDoneQnnnH  output  1  image fully written.
REQ-013 LoadErrQnnnH  output  1  sticky format error.

Function
REQ-014 Image format: a sequence of records; each record is a 4-byte base address (LE), a 2-byte word count N (LE), then N*4 data bytes (LE per word); N=0 is the end-of-image marker.
REQ-015 FSM states: HDR_ADDR, HDR_CNT, DATA, WRITE, DONE, ERR; reset state HDR_ADDR.
REQ-016 HDR_ADDR: accept 4 bytes -> HDR_CNT; if address bits [1:0] are nonzero after the 4th byte -> ERR.
REQ-017 HDR_CNT: accept 2 bytes; N=0 -> DONE; N>0 -> DATA with the word counter loaded to N.
REQ-018 DATA: accept 4 bytes into the word assembler; after the 4th byte -> WRITE.
REQ-019 WRITE: ByteReadyQnnnH=0; MemWrEnQnnnH=1 with stable address and data until MemWrReadyQnnnH=1; on completion, address +4 and counter -1; counter reaching 0 -> HDR_ADDR, otherwise -> DATA.
REQ-020 MemWrEnQnnnH rises in the cycle after the 4th data byte is accepted; minimum throughput is 1 word per 5 cycles.
REQ-021 ByteReadyQnnnH=1 only in HDR_ADDR, HDR_CNT and DATA; it is registered and has no combinational path from ByteValidQnnnH.
REQ-022 Address arithmetic is modulo 2^ADDR_W: 0xFFFFFFFC+4 wraps to 0x00000000 with no error.
REQ-023 Counter is 16 bits; N=65535 is legal.
REQ-024 DONE: terminal state until reset; LoadDoneQnnnH=1 and CoreRstQnnnH=0 starting in the cycle after the last byte of the end marker is accepted; ByteReadyQnnnH=0.
REQ-025 ERR: terminal state until reset; LoadErrQnnnH=1, CoreRstQnnnH=1, ByteReadyQnnnH=0, MemWrEnQnnnH=0.
REQ-026 Bubbles (ByteValidQnnnH low) in any byte-accepting state cause no state change.

Reset
REQ-027 Asserting RstQnnnH at any time, including mid-record or mid-write, returns the FSM to HDR_ADDR asynchronously and discards any partial word.
REQ-028 Output reset values: ByteReadyQnnnH=0, MemWrEnQnnnH=0, MemWrAddrQnnnH=0, MemWrDataQnnnH=0, CoreRstQnnnH=1, LoadDoneQnnnH=0, LoadErrQnnnH=0.
REQ-029 ByteReadyQnnnH rises in the first cycle after RstQnnnH deasserts.

Configuration
REQ-030 With LOTR_LOADER_CHKSUM_EN defined, every record, including the end marker, is followed by one checksum byte (state CHK). The 8-bit sum of all record bytes plus the checksum byte must equal 0x00.
REQ-031 On a checksum mismatch the FSM enters ERR; on a match it enters HDR_ADDR, or DONE for the end marker. DONE timing per REQ-024 is measured from the checksum byte.
REQ-032 With LOTR_LOADER_CHKSUM_EN undefined, no checksum byte exists and the CHK state and adder logic are absent.

Verification
REQ-033 Stream 00 00 40 00 01 00 13 05 00 00 then end marker 00 00 00 00 00 00 -> one write, addr 0x00400000, data 0x00000513; then LoadDoneQnnnH=1 and CoreRstQnnnH=0.
REQ-034 Header address 0x00400002 -> LoadErrQnnnH=1, no writes, CoreRstQnnnH stays 1, ByteReadyQnnnH=0.
REQ-035 Record with N=3 at 0x00000000 and MemWrReadyQnnnH held low 5 cycles per write -> writes at 0x0, 0x4, 0x8; address and data stable while stalled; ByteReadyQnnnH=0 during stalls.
REQ-036 Record at 0xFFFFFFFC with N=2 -> writes at 0xFFFFFFFC then 0x00000000, no error.
REQ-037 RstQnnnH pulsed after 2 data bytes of a word -> no write issued; a full image sent afterwards loads correctly.
REQ-038 With LOTR_LOADER_CHKSUM_EN: the REQ-033 record followed by checksum 0xA7 -> write accepted. The same record followed by checksum 0xA6 -> ERR after the write, LoadErrQnnnH=1.
